// File: rtl/fp_div.sv
// fp_div: multi-cycle binary32 divider, restoring radix-2,
// one quotient bit per cycle behind a start/done handshake.
module fp_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_NORM,
    S_DONE
  } state_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [24:0]        r_q, r_d;
  logic [24:0]        q_q, q_d;
  logic [23:0]        mb_q, mb_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [31:0]        res_q, res_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               dbz_q, dbz_d;

  logic               sa, sb, s_ab;
  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic               a_nan, b_nan;
  logic               a_inf, b_inf;
  logic               a_zero, b_zero;
  logic               spec_hit;
  logic [31:0]        spec_res;
  logic               spec_dbz;

  logic               q_bit;
  logic [23:0]        r_sub;
  logic signed [9:0]  exp_n;
  logic [22:0]        man_n;
  logic [31:0]        norm_res;

  assign sa = a[31];
  assign ea = a[30:23];
  assign fa = a[22:0];
  assign sb = b[31];
  assign eb = b[30:23];
  assign fb = b[22:0];
  assign s_ab = sa ^ sb;

  // Exponent 0 is zero, so subnormals flush to signed zero.
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = !(|ea);
  assign b_zero = !(|eb);

  // Special operand pairs, resolved in priority order.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = 32'h0;
    spec_dbz = 1'b0;
    if (a_nan || b_nan
        || (a_zero && b_zero)
        || (a_inf && b_inf)) begin
      spec_res = QNAN;
    end else if (a_inf) begin
      spec_res = {s_ab, 8'hFF, 23'h0};
    end else if (b_inf) begin
      spec_res = {s_ab, 31'h0};
    end else if (b_zero) begin
      spec_res = {s_ab, 8'hFF, 23'h0};
      spec_dbz = 1'b1;
    end else if (a_zero) begin
      spec_res = {s_ab, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring step; the remainder after a step is below mb.
  always_comb begin
    q_bit = (r_q >= {1'b0, mb_q});
    r_sub = r_q[23:0];
    if (q_bit) begin
      r_sub = 24'(r_q - {1'b0, mb_q});
    end
  end

  // Normalise the 25-bit quotient and range-check the exponent.
  always_comb begin
    exp_n    = exp_q;
    man_n    = q_q[23:1];
    norm_res = 32'h0;
    if (!q_q[24]) begin
      exp_n = exp_q - 10'sd1;
      man_n = q_q[22:0];
    end
    if (exp_n >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'h0};
    end else if (exp_n <= 10'sd0) begin
      norm_res = {sign_q, 31'h0};
    end else begin
      norm_res = {sign_q, exp_n[7:0], man_n};
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    mb_d    = mb_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d = s_ab;
          if (spec_hit) begin
            res_d   = spec_res;
            dbz_d   = spec_dbz;
            state_d = S_DONE;
          end else begin
            mb_d    = {1'b1, fb};
            r_d     = {2'b01, fa};
            q_d     = 25'h0;
            cnt_d   = 5'd0;
            exp_d   = $signed({2'b00, ea})
                    - $signed({2'b00, eb})
                    + 10'sd127;
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        q_d   = {q_q[23:0], q_bit};
        r_d   = {r_sub, 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) begin
          cnt_d   = 5'd0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        res_d   = norm_res;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_DIVIDE)
          || (state_d == S_NORM);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      r_q     <= 25'h0;
      q_q     <= 25'h0;
      mb_q    <= 24'h0;
      sign_q  <= 1'b0;
      exp_q   <= 10'sd0;
      res_q   <= 32'h0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      mb_q    <= mb_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
    end
  end

  assign result      = res_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule
